// File: rtl/wb_pkg.sv
// Shared Wishbone slave definitions: FSM state encoding and the
// interconnect's slave-select field width.
package wb_pkg;

    localparam int WB_SLAVE_SEL_BITS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } wb_slv_state_t;

endpackage

// File: rtl/wb_sram_array.sv
// Single-port synchronous RAM with per-byte write enables and a registered
// read port that only updates on read accesses.
module wb_sram_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DEPTH_LOG2-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int k = 0; k < DATA_WIDTH/8; k++) begin
                    if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone B4 classic-cycle SRAM slave with configurable wait states and
// error termination for addresses beyond the populated memory.
module wb_sram_slave
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int SEL_WIDTH   = DATA_WIDTH/8,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic [SEL_WIDTH-1:0]  sel_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
    output logic                  err_o
);

    localparam int OFF    = $clog2(SEL_WIDTH);
    localparam int IDX_LO = OFF;
    localparam int IDX_HI = DEPTH_LOG2 + OFF - 1;
    localparam int RNG_HI = ADDR_WIDTH - WB_SLAVE_SEL_BITS - 1;
    localparam int RNG_LO = DEPTH_LOG2 + OFF;
    localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    wb_slv_state_t         state;
    logic [3:0]            cnt;
    logic                  q_we, q_oor;
    logic [DEPTH_LOG2-1:0] q_idx;
    logic [DATA_WIDTH-1:0] q_dat;
    logic [SEL_WIDTH-1:0]  q_sel;
    logic                  rd_zero;

    logic                  req, idle, in_oor, acc;
    logic                  cur_we, cur_oor;
    logic [DEPTH_LOG2-1:0] cur_idx;
    logic [DATA_WIDTH-1:0] cur_dat, ram_rdata;
    logic [SEL_WIDTH-1:0]  cur_sel;
    logic                  unused_adr;

    // Byte offset and slave-select bits carry no meaning here.
    assign unused_adr = ^adr_i;

    generate
        if (RNG_HI >= RNG_LO) begin : g_rng
            assign in_oor = |adr_i[RNG_HI:RNG_LO];
        end else begin : g_no_rng
            assign in_oor = 1'b0;
        end
    endgenerate

    assign req  = cyc_i & stb_i;
    assign idle = (state == IDLE);

    // With zero wait states the access uses the live bus; otherwise the capture.
    assign cur_we  = idle ? we_i : q_we;
    assign cur_oor = idle ? in_oor : q_oor;
    assign cur_idx = idle ? adr_i[IDX_HI:IDX_LO] : q_idx;
    assign cur_dat = idle ? dat_i : q_dat;
    assign cur_sel = idle ? sel_i : q_sel;

    assign acc = !rst_i && ((idle && req && (WAIT_STATES == 0)) ||
                            ((state == WAIT) && cyc_i && (cnt == 4'd0)));

    wb_sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk_i),
        .en    (acc && !cur_oor),
        .we    (cur_we),
        .be    (cur_sel),
        .addr  (cur_idx),
        .wdata (cur_dat),
        .rdata (ram_rdata)
    );

    // rd_zero is updated on the same edge as the RAM read register, so the
    // pair behaves as one registered read-data output.
    assign dat_o = rd_zero ? '0 : ram_rdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            rd_zero <= 1'b1;
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            if (acc) begin
                ack_o <= !cur_oor;
                err_o <= cur_oor;
                if (!cur_we) rd_zero <= cur_oor;
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        q_we  <= we_i;
                        q_oor <= in_oor;
                        q_idx <= adr_i[IDX_HI:IDX_LO];
                        q_dat <= dat_i;
                        q_sel <= sel_i;
                        if (WAIT_STATES == 0) begin
                            state <= RESP;
                        end else begin
                            cnt   <= WS_LOAD;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!cyc_i) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed plus randomized bench: u0 has 1 wait state and a 4-bit range field,
// u1 has no wait states and an empty range field.
module tb_wb_sram_slave;

    logic clk, rst;
    logic cyc0, stb0, we0, ack0, err0;
    logic [19:0] adr0;
    logic [31:0] dat0, rd0;
    logic [3:0]  sel0;
    logic cyc1, stb1, we1, ack1, err1;
    logic [15:0] adr1;
    logic [31:0] dat1, rd1;
    logic [3:0]  sel1;

    int errors = 0;
    int checks = 0;
    logic [31:0] m0 [1024];

    wb_sram_slave #(.ADDR_WIDTH(20), .DATA_WIDTH(32), .SEL_WIDTH(4),
                    .DEPTH_LOG2(10), .WAIT_STATES(1)) u0 (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc0), .stb_i(stb0), .we_i(we0),
        .adr_i(adr0), .dat_i(dat0), .sel_i(sel0), .dat_o(rd0),
        .ack_o(ack0), .err_o(err0));

    wb_sram_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .SEL_WIDTH(4),
                    .DEPTH_LOG2(10), .WAIT_STATES(0)) u1 (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc1), .stb_i(stb1), .we_i(we1),
        .adr_i(adr1), .dat_i(dat1), .sel_i(sel1), .dat_o(rd1),
        .ack_o(ack1), .err_o(err1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Classic master: hold the request until termination, then release.
    task automatic xfer(input int d, input logic w, input logic [19:0] a,
                        input logic [31:0] wd, input logic [3:0] s,
                        output logic a_seen, output logic e_seen,
                        output int lat, output logic [31:0] rd);
        @(negedge clk);
        if (d == 0) begin
            cyc0 = 1; stb0 = 1; we0 = w; adr0 = a; dat0 = wd; sel0 = s;
        end else begin
            cyc1 = 1; stb1 = 1; we1 = w; adr1 = a[15:0]; dat1 = wd; sel1 = s;
        end
        lat = -1; a_seen = 0; e_seen = 0; rd = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            a_seen = (d == 0) ? ack0 : ack1;
            e_seen = (d == 0) ? err0 : err1;
            if (a_seen || e_seen) begin
                lat = k;
                rd  = (d == 0) ? rd0 : rd1;
                break;
            end
        end
        if (d == 0) begin cyc0 = 0; stb0 = 0; end
        else        begin cyc1 = 0; stb1 = 0; end
        chk("timeout", 32'(lat != -1), 32'd1);
        @(negedge clk);
        chk("single_pulse", (d == 0) ? 32'(ack0 | err0) : 32'(ack1 | err1), 32'd0);
    endtask

    // Reference for u0: range field is address bits [15:12], word index [11:2].
    task automatic op0(input logic w, input logic [19:0] a, input logic [31:0] wd,
                       input logic [3:0] s);
        logic oor, as, es;
        int idx, lat;
        logic [31:0] rd;
        oor = ((a >> 12) & 20'hF) != 0;
        idx = int'((a >> 2) & 20'h3FF);
        xfer(0, w, a, wd, s, as, es, lat, rd);
        chk("u0_latency", 32'(lat), 32'd2);
        chk("u0_ack", 32'(as), 32'(!oor));
        chk("u0_err", 32'(es), 32'(oor));
        if (!w) chk("u0_rdata", rd, oor ? 32'd0 : m0[idx]);
        if (w && !oor)
            for (int b = 0; b < 4; b++)
                if (s[b]) m0[idx][8*b +: 8] = wd[8*b +: 8];
    endtask

    initial begin
        int acks, errs, doubles;
        logic prev, as, es;
        int lat;
        logic [31:0] rd;

        rst = 1;
        cyc0 = 0; stb0 = 0; we0 = 0; adr0 = '0; dat0 = '0; sel0 = '0;
        cyc1 = 0; stb1 = 0; we1 = 0; adr1 = '0; dat1 = '0; sel1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack0", 32'(ack0), 0);
        chk("rst_err0", 32'(err0), 0);
        chk("rst_dat0", rd0, 0);
        chk("rst_ack1", 32'(ack1), 0);
        chk("rst_dat1", rd1, 0);
        rst = 0;

        op0(1, 20'h00010, 32'hDEADBEEF, 4'hF);
        op0(0, 20'h00010, 32'h0, 4'hF);
        op0(1, 20'h00010, 32'h11223344, 4'h5);
        op0(0, 20'h00010, 32'h0, 4'hF);
        chk("byte_en_value", m0[4], 32'hDE22BE44);

        op0(1, 20'h00000, 32'hCAFEF00D, 4'hF);
        op0(1, 20'h01000, 32'h12345678, 4'hF);
        op0(0, 20'h01000, 32'h0, 4'hF);
        op0(0, 20'h00000, 32'h0, 4'hF);

        // Abort: drop cyc while the write is waiting.
        @(negedge clk);
        cyc0 = 1; stb0 = 1; we0 = 1; adr0 = 20'h00010; dat0 = 32'h55555555; sel0 = 4'hF;
        @(posedge clk);
        @(negedge clk);
        cyc0 = 0; stb0 = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_no_term", 32'(ack0 | err0), 0);
        end
        op0(0, 20'h00010, 32'h0, 4'hF);

        // Reset while a write is waiting.
        @(negedge clk);
        cyc0 = 1; stb0 = 1; we0 = 1; adr0 = 20'h00010; dat0 = 32'h77777777; sel0 = 4'hF;
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("midrst_ack", 32'(ack0), 0);
        chk("midrst_err", 32'(err0), 0);
        chk("midrst_dat", rd0, 0);
        rst = 0; cyc0 = 0; stb0 = 0;
        op0(0, 20'h00010, 32'h0, 4'hF);

        // Randomized traffic over a fully initialised 16-word window.
        for (int i = 0; i < 16; i++) op0(1, 20'(i << 2), $urandom, 4'hF);
        for (int i = 0; i < 40; i++) begin
            logic [19:0] a;
            logic [3:0] hi;
            hi = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            a = {4'($urandom_range(0, 15)), hi, 8'd0, 4'($urandom_range(0, 15))};
            a[5:4] = 2'($urandom_range(0, 3));
            a[1:0] = 2'($urandom_range(0, 3));
            a[3:2] = 2'($urandom_range(0, 3));
            op0(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
        end

        // u1: stb held high continuously; 0x1000 aliases word 0 (no range field).
        @(negedge clk);
        cyc1 = 1; stb1 = 1; we1 = 1; adr1 = 16'h1000; dat1 = 32'hA5A50001; sel1 = 4'hF;
        acks = 0; errs = 0; doubles = 0; prev = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ack1) acks++;
            if (err1) errs++;
            if (ack1 && prev) doubles++;
            prev = ack1;
        end
        cyc1 = 0; stb1 = 0;
        chk("u1_ack_count", 32'(acks), 32'd4);
        chk("u1_err_count", 32'(errs), 32'd0);
        chk("u1_double_ack", 32'(doubles), 32'd0);
        @(negedge clk);
        xfer(1, 0, 20'h00000, 32'h0, 4'hF, as, es, lat, rd);
        chk("u1_latency", 32'(lat), 32'd1);
        chk("u1_ack", 32'(as), 32'd1);
        chk("u1_err", 32'(es), 32'd0);
        chk("u1_rdata", rd, 32'hA5A50001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
